// File: rtl/disk_stream.sv
// disk_stream: beat-streaming backing store with request/response handshake.
// Bytes are interleaved across NBANKS byte-wide banks. Any NBANKS consecutive
// bytes hit every bank exactly once, so a beat moves NBANKS bytes in one
// cycle at any alignment.
`timescale 1ns/1ps
module disk_stream #(
  parameter int NBANKS      = 8,
  parameter int ADDR_W      = 16,
  parameter int SIZE_W      = 13,
  parameter int SEEK_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [SIZE_W-1:0]         req_size,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [8*NBANKS-1:0]       rd_data,
  output logic [$clog2(NBANKS):0]   rd_bytes,
  output logic                      rd_last,
  output logic                      wr_ready,
  input  logic                      wr_valid,
  input  logic [8*NBANKS-1:0]       wr_data,
  output logic                      busy,
  output logic                      done
);
  localparam int L     = $clog2(NBANKS);
  localparam int BW    = L + 1;
  localparam int ROW_W = ADDR_W - L;
  localparam int ROWS  = 1 << ROW_W;
  localparam int CNT_W = $clog2(SEEK_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SEEK, XFER, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_reg;
  logic [SIZE_W-1:0]   rem_reg;
  logic                we_reg;
  logic [CNT_W-1:0]    seek_cnt;
  logic [L-1:0]        rot_reg;      // bank holding byte 0 of the presented beat
  logic [8*NBANKS-1:0] bank_flat;    // registered bank read outputs, bank order

  logic [BW-1:0]       step;
  logic                last_beat;
  logic                rd_hs;
  logic                wr_hs;
  logic                seek_expire;
  logic                load_beat;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [SIZE_W-1:0]   fetch_rem;
  logic [BW-1:0]       fetch_bytes;
  logic                fetch_last;
  logic [L-1:0]        src;

  assign busy = (state != IDLE);

  // Beat bookkeeping: size of the current beat and the beat that follows it
  always_comb begin
    step        = (rem_reg >= SIZE_W'(NBANKS)) ? BW'(NBANKS) : rem_reg[BW-1:0];
    last_beat   = (rem_reg <= SIZE_W'(NBANKS));
    rd_hs       = EN && (state == XFER) && !we_reg && rd_valid && rd_ready;
    wr_hs       = EN && (state == XFER) && we_reg && wr_ready && wr_valid;
    seek_expire = EN && (state == SEEK) && (seek_cnt == CNT_W'(1));
    load_beat   = (seek_expire && !we_reg) || (rd_hs && !last_beat);
    fetch_addr  = rd_hs ? addr_reg + ADDR_W'(step) : addr_reg;
    fetch_rem   = rd_hs ? rem_reg - SIZE_W'(step) : rem_reg;
    fetch_bytes = (fetch_rem >= SIZE_W'(NBANKS)) ? BW'(NBANKS) : fetch_rem[BW-1:0];
    fetch_last  = (fetch_rem <= SIZE_W'(NBANKS));
  end

  generate
    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
      logic [7:0]       mem [ROWS];
      logic [7:0]       q;
      logic [L-1:0]     wr_k;
      logic [ROW_W-1:0] wr_row;
      logic [ROW_W-1:0] rd_row;
      logic             wr_en;

      // Banks below the start offset hold bytes that spilled into the next row
      assign wr_k   = L'(gi) - addr_reg[L-1:0];
      assign wr_row = addr_reg[ADDR_W-1:L]
                    + {{(ROW_W-1){1'b0}}, (L'(gi) < addr_reg[L-1:0])};
      assign rd_row = fetch_addr[ADDR_W-1:L]
                    + {{(ROW_W-1){1'b0}}, (L'(gi) < fetch_addr[L-1:0])};
      assign wr_en  = wr_hs && (BW'(wr_k) < step);
      assign bank_flat[8*gi +: 8] = q;

      // Bank array: byte write on accepted write beats, registered read on beat load
      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[wr_row] <= wr_data[8*wr_k +: 8];
        end
        if (load_beat) begin
          q <= mem[rd_row];
        end
      end
    end
  endgenerate

  // Rotate bank outputs into beat byte order and zero bytes past rd_bytes
  always_comb begin
    rd_data = '0;
    src     = '0;
    for (int k = 0; k < NBANKS; k++) begin
      src = rot_reg + L'(k);
      if (BW'(k) < rd_bytes) begin
        rd_data[8*k +: 8] = bank_flat[8*src +: 8];
      end
    end
  end

  // Request FSM with registered handshake outputs; EN low holds everything
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      addr_reg  <= '0;
      rem_reg   <= '0;
      we_reg    <= 1'b0;
      seek_cnt  <= '0;
      rot_reg   <= '0;
      req_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_bytes  <= '0;
      rd_last   <= 1'b0;
      wr_ready  <= 1'b0;
      done      <= 1'b0;
    end else if (EN) begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr_reg  <= req_addr;
            rem_reg   <= req_size;
            we_reg    <= req_we;
            seek_cnt  <= CNT_W'(SEEK_CYCLES);
            if (req_size == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SEEK;
            end
          end
        end
        SEEK: begin
          if (seek_expire) begin
            state <= XFER;
            if (we_reg) begin
              wr_ready <= 1'b1;
            end else begin
              rd_valid <= 1'b1;
              rd_bytes <= fetch_bytes;
              rd_last  <= fetch_last;
              rot_reg  <= fetch_addr[L-1:0];
            end
          end else begin
            seek_cnt <= seek_cnt - CNT_W'(1);
          end
        end
        XFER: begin
          if (wr_hs) begin
            addr_reg <= addr_reg + ADDR_W'(step);
            rem_reg  <= rem_reg - SIZE_W'(step);
            if (last_beat) begin
              wr_ready <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end else if (rd_hs) begin
            addr_reg <= fetch_addr;
            rem_reg  <= fetch_rem;
            if (last_beat) begin
              rd_valid <= 1'b0;
              rd_bytes <= '0;
              rd_last  <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              rd_bytes <= fetch_bytes;
              rd_last  <= fetch_last;
              rot_reg  <= fetch_addr[L-1:0];
            end
          end
        end
        default: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_disk_stream.sv
// Directed bench for disk_stream: preloads through the write path, then checks
// aligned/wrapped reads, backpressure, gapped writes, zero size, reset abort
// and EN freeze against hand-computed values.
`timescale 1ns/1ps
module tb_disk_stream;
  logic        clk = 1'b0;
  logic        RST;
  logic        EN;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [12:0] req_size;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic [3:0]  rd_bytes;
  logic        rd_last;
  logic        wr_ready;
  logic        wr_valid;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_acc    = 0;

  disk_stream #(.NBANKS(8), .ADDR_W(16), .SIZE_W(13), .SEEK_CYCLES(4)) dut (
    .clk(clk), .RST(RST), .EN(EN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_bytes(rd_bytes), .rd_last(rd_last),
    .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present a request once req_ready is seen; returns at the negedge after acceptance
  task automatic send_req(input logic we, input logic [15:0] a, input logic [12:0] s);
    int waited = 0;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    $display("req we=%0d addr=%h size=%0d", we, a, s);
    req_we = we; req_addr = a; req_size = s; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic put_beat(input logic [63:0] d, input int gap, output int t);
    repeat (gap) @(negedge clk);
    t = -1;
    for (int i = 0; i < 50 && t < 0; i++) begin
      if (wr_ready) t = cyc - t_acc;
      else @(negedge clk);
    end
    if (t < 0) check("wr_ready_timeout", 0, 1);
    else begin
      wr_data = d; wr_valid = 1'b1;
      @(negedge clk);
      wr_valid = 1'b0; wr_data = '0;
    end
  endtask

  task automatic get_beat(output logic [63:0] d, output logic [3:0] b, output logic l, output int t);
    t = -1; d = '0; b = '0; l = 1'b0;
    for (int i = 0; i < 50 && t < 0; i++) begin
      if (rd_valid) begin
        t = cyc - t_acc; d = rd_data; b = rd_bytes; l = rd_last;
      end
      @(negedge clk);
    end
    if (t < 0) check("rd_valid_timeout", 0, 1);
  endtask

  task automatic write_block(input logic [15:0] a, input logic [12:0] s,
                             input logic [63:0] beats [3], input int n, input int gap,
                             output int t_first);
    int t;
    send_req(1'b1, a, s);
    t_first = -1;
    for (int j = 0; j < n; j++) begin
      put_beat(beats[j], (j == 0) ? 0 : gap, t);
      if (j == 0) t_first = t;
    end
    check("wr_done", done, 1);
  endtask

  task automatic read_block(input string tag, input logic [15:0] a, input logic [12:0] s,
                            input logic [63:0] exp_d [3], input logic [3:0] exp_b [3],
                            input int n, output int t_first);
    logic [63:0] d; logic [3:0] b; logic l; int t;
    send_req(1'b0, a, s);
    t_first = -1;
    for (int j = 0; j < n; j++) begin
      get_beat(d, b, l, t);
      if (j == 0) t_first = t;
      check({tag, "_data"}, d, exp_d[j]);
      check({tag, "_bytes"}, b, exp_b[j]);
      check({tag, "_last"}, l, (j == n - 1));
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_last_vs_done"}, rd_last, 0);
  endtask

  logic [63:0] wb [3];
  logic [63:0] ed [3];
  logic [3:0]  eb [3];
  logic [63:0] d;
  logic [3:0]  b;
  logic        l;
  logic [63:0] held;
  logic        stalled;
  int          t;
  int          nb;
  logic        saw_done;

  initial begin
    RST = 1'b1; EN = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    rd_ready = 1'b1; wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {req_ready, rd_valid, rd_last, wr_ready, busy, done}, 6'b0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_bytes", rd_bytes, 0);
    RST = 1'b0;
    @(negedge clk);
    check("req_ready_after_rst", req_ready, 1);

    // Preloads through the write path
    wb[0] = 64'h0706050403020100; wb[1] = 64'h0F0E0D0C0B0A0908; wb[2] = '0;
    write_block(16'h0010, 13'd16, wb, 2, 0, t);
    check("wr_first_latency", t, 4);
    wb[0] = 64'h4746454443424140; wb[1] = 64'h4F4E4D4C4B4A4948; wb[2] = 64'h5756555453525150;
    write_block(16'h0100, 13'd24, wb, 3, 0, t);
    wb[0] = 64'h11223344DDCCBBAA; wb[1] = '0; wb[2] = '0;
    write_block(16'hFFFE, 13'd4, wb, 1, 0, t);

    // Aligned read
    ed[0] = 64'h0706050403020100; ed[1] = 64'h0F0E0D0C0B0A0908; ed[2] = '0;
    eb[0] = 4'd8; eb[1] = 4'd8; eb[2] = '0;
    read_block("aligned", 16'h0010, 13'd16, ed, eb, 2, t);
    check("aligned_first_latency", t, 4);
    check("aligned_done_time", cyc - t_acc, 6);

    // Wrap across the top of the address space, partial beat
    ed[0] = 64'h00000000DDCCBBAA; eb[0] = 4'd4;
    read_block("wrap", 16'hFFFE, 13'd4, ed, eb, 1, t);

    // Backpressure: rd_ready pattern 1,0,0,1,0,0,...
    ed[0] = 64'h4746454443424140; ed[1] = 64'h4F4E4D4C4B4A4948; ed[2] = 64'h5756555453525150;
    send_req(1'b0, 16'h0100, 13'd24);
    nb = 0; stalled = 1'b0; held = '0; saw_done = 1'b0;
    for (int k = 0; k < 80 && !saw_done; k++) begin
      if (done) saw_done = 1'b1;
      else begin
        rd_ready = ((k % 3) == 0);
        if (rd_valid) begin
          if (stalled) check("bp_hold", rd_data, held);
          if (rd_ready) begin
            if (nb < 3) begin
              check("bp_data", rd_data, ed[nb]);
              check("bp_last", rd_last, (nb == 2));
            end
            nb++;
            stalled = 1'b0;
          end else begin
            held = rd_data;
            stalled = 1'b1;
          end
        end
        @(negedge clk);
      end
    end
    rd_ready = 1'b1;
    check("bp_beat_count", nb, 3);
    check("bp_done_seen", saw_done, 1);

    // Gapped write into the middle of the preloaded window, then read back
    wb[0] = 64'h8877665544332211; wb[1] = 64'h000000000000AA99; wb[2] = '0;
    write_block(16'h0103, 13'd10, wb, 2, 1, t);
    ed[0] = 64'h8877665544332211; ed[1] = 64'h000000000000AA99;
    eb[0] = 4'd8; eb[1] = 4'd2;
    read_block("readback", 16'h0103, 13'd10, ed, eb, 2, t);
    ed[0] = 64'h000000000000004D; eb[0] = 4'd1;
    read_block("untouched", 16'h010D, 13'd1, ed, eb, 1, t);

    // Zero-size request
    send_req(1'b0, 16'h0040, 13'd0);
    check("zero_done", done, 1);
    check("zero_rd_valid", rd_valid, 0);
    @(negedge clk);
    check("zero_done_pulse", done, 0);

    // Reset abort at the first beat
    rd_ready = 1'b0;
    send_req(1'b0, 16'h0010, 13'd32);
    for (int k = 0; k < 50 && !rd_valid; k++) @(negedge clk);
    check("abort_beat_present", rd_valid, 1);
    RST = 1'b1;
    @(negedge clk);
    check("abort_ctrl", {req_ready, rd_valid, rd_last, wr_ready, busy, done}, 6'b0);
    check("abort_rd_data", rd_data, 0);
    check("abort_rd_bytes", rd_bytes, 0);
    RST = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    check("abort_req_ready", req_ready, 1);

    // EN freeze for three cycles during SEEK
    send_req(1'b0, 16'h0010, 13'd8);
    @(negedge clk);
    EN = 1'b0;
    repeat (3) @(negedge clk);
    EN = 1'b1;
    get_beat(d, b, l, t);
    check("freeze_first_latency", t, 7);
    check("freeze_data", d, 64'h0706050403020100);
    check("freeze_last", l, 1);
    check("freeze_done", done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
